div: RTL and testbench



---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 23 ++
 rtl/div.sv | 133 +++++++++++++
 tb/tb_div.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative radix-2 divider.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package div_pkg;

    localparam int DIV_W     = 32;  // operand / quotient / remainder width
    localparam int DIV_CNT_W = 6;   // step counter width
    localparam int DIV_STEPS = 32;  // restoring steps per operation

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divState_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
// Ports: remIn (partial remainder), dividendBit (next dividend MSB), divisor (magnitude),
//        remOut (next partial remainder), quoBit (quotient bit produced by this step).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic             dividendBit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic             quoBit
);

    logic [WIDTH:0] trial;

    assign trial  = {remIn, dividendBit} - {1'b0, divisor};
    assign quoBit = ~trial[WIDTH];
    // remIn < divisor always holds, so the shifted remainder never overflows WIDTH bits.
    assign remOut = quoBit ? trial[WIDTH-1:0] : {remIn[WIDTH-2:0], dividendBit};

endmodule

// File: rtl/div.sv
// Iterative radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu (quotient and remainder together).
// Latency: 33 cycles from the accepting edge (inclusive) to res_valid; 1 cycle on early-out when DIV_EARLY_OUT_EN is defined.
// Backpressure: div_ready only in IDLE; result held in DONE until res_ready; cancel aborts in any state.
// Ports: div_clk, reset (sync, active-high); div_valid/div_ready/div_signed/x/y issue side;
//        cancel flush; res_valid/res_ready/s (quotient)/r (remainder) result side.
// Build option: DIV_EARLY_OUT_EN skips the iteration when y==0 or |x|<|y|.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             div_clk,
    input  logic             reset,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cancel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r
);

    localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(DIV_STEPS - 1);

    divState_t              state;
    logic [DIV_CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]       dividend;   // |x|, shifted left one bit per step
    logic [WIDTH-1:0]       divisor;    // |y|
    logic [WIDTH-1:0]       rem;
    logic [WIDTH-1:0]       quo;
    logic [WIDTH-1:0]       xOrig;
    logic                   signQ;
    logic                   signR;
    logic                   yZero;

    logic [WIDTH-1:0]       xAbs;
    logic [WIDTH-1:0]       yAbs;
    logic                   earlyOut;
    logic [WIDTH-1:0]       stepRem;
    logic                   stepQ;
    logic [WIDTH-1:0]       qFinal;
    logic [WIDTH-1:0]       qSigned;
    logic [WIDTH-1:0]       rSigned;

    assign div_ready = (state == IDLE);
    assign res_valid = (state == DONE);

    assign xAbs = (div_signed && x[WIDTH-1]) ? -x : x;
    assign yAbs = (div_signed && y[WIDTH-1]) ? -y : y;

`ifdef DIV_EARLY_OUT_EN
    assign earlyOut = (y == '0) || (xAbs < yAbs);
`else
    assign earlyOut = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) uStep (
        .remIn       (rem),
        .dividendBit (dividend[WIDTH-1]),
        .divisor     (divisor),
        .remOut      (stepRem),
        .quoBit      (stepQ)
    );

    // Values as they will stand after the current step; only consumed on the last one.
    assign qFinal  = {quo[WIDTH-2:0], stepQ};
    assign qSigned = signQ ? -qFinal : qFinal;
    assign rSigned = signR ? -stepRem : stepRem;

    always_ff @(posedge div_clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            xOrig    <= '0;
            signQ    <= 1'b0;
            signR    <= 1'b0;
            yZero    <= 1'b0;
            s        <= '0;
            r        <= '0;
        end else if (cancel) begin
            // Flush wins over everything, including a simultaneous issue; s/r left as-is.
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (div_valid) begin
                        dividend <= xAbs;
                        divisor  <= yAbs;
                        xOrig    <= x;
                        signQ    <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                        signR    <= div_signed & x[WIDTH-1];
                        yZero    <= (y == '0);
                        rem      <= '0;
                        quo      <= '0;
                        cnt      <= '0;
                        if (earlyOut) begin
                            state <= DONE;
                            s     <= (y == '0) ? '1 : '0;
                            r     <= x;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem      <= stepRem;
                    quo      <= qFinal;
                    dividend <= {dividend[WIDTH-2:0], 1'b0};
                    cnt      <= cnt + DIV_CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state <= DONE;
                        s     <= yZero ? '1 : qSigned;
                        r     <= yZero ? xOrig : rSigned;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus randomized operands against an arithmetic model.
// Latency: n/a.
// Backpressure: exercises res_ready stalls, cancel and mid-operation reset.
module tb_div;

    logic        div_clk;
    logic        reset;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic        cancel;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] s;
    logic [31:0] r;

    int checks = 0;
    int errors = 0;

    div #(.WIDTH(32)) dut (
        .div_clk    (div_clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .x          (x),
        .y          (y),
        .cancel     (cancel),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .s          (s),
        .r          (r)
    );

    initial div_clk = 1'b0;
    always #5 div_clk = ~div_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, remainder follows dividend.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint qa;
        longint ra;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            qa = longint'($signed(a)) / longint'($signed(b));
            ra = longint'($signed(a)) % longint'($signed(b));
        end else begin
            qa = longint'(a) / longint'(b);
            ra = longint'(a) % longint'(b);
        end
        return {qa[31:0], ra[31:0]};
    endfunction

    function automatic longint mag(input logic [31:0] a, input logic sgn);
        longint v;
        v = sgn ? longint'($signed(a)) : longint'(a);
        return (v < 0) ? -v : v;
    endfunction

    // Edges counted from the accepting edge (counted as 1) until res_valid is seen.
    function automatic int expLat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
`ifdef DIV_EARLY_OUT_EN
        if (b == 32'd0 || mag(a, sgn) < mag(b, sgn)) return 1;
`endif
        return 33;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        x          = a;
        y          = b;
        div_signed = sgn;
        div_valid  = 1'b1;
        @(posedge div_clk); #1;
        div_valid  = 1'b0;
    endtask

    task automatic waitResult(input string tag, output int lat);
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(posedge div_clk); #1;
            lat++;
        end
        if (!res_valid) check({tag, "_timeout"}, 32'(res_valid), 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [63:0] e;
        int lat;
        e = model(a, b, sgn);
        check({tag, "_ready"}, 32'(div_ready), 32'd1);
        issue(a, b, sgn);
        waitResult(tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(expLat(a, b, sgn)));
        check({tag, "_s"}, s, e[63:32]);
        check({tag, "_r"}, r, e[31:0]);
        @(posedge div_clk); #1;
        check({tag, "_idle"}, {30'd0, div_ready, res_valid}, 32'b10);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hs;
        logic [31:0] hr;
        logic        sawValid;
        int          lat;

        reset      = 1'b1;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        x          = '0;
        y          = '0;
        cancel     = 1'b0;
        res_ready  = 1'b1;
        repeat (2) @(posedge div_clk);
        #1;
        reset = 1'b0;
        check("rst_ready", 32'(div_ready), 32'd1);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_s", s, 32'd0);
        check("rst_r", r, 32'd0);

        runOp("u100_7", 32'd100, 32'd7, 1'b0);
        runOp("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        runOp("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        runOp("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        runOp("uovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        runOp("dz_u", 32'h1234_5678, 32'd0, 1'b0);
        runOp("dz_s", 32'h1234_5678, 32'd0, 1'b1);
        runOp("dz_neg", 32'h8765_4321, 32'd0, 1'b1);
        runOp("small_s", 32'hFFFF_FFFD, 32'd10, 1'b1);
        runOp("small_u", 32'd3, 32'd10, 1'b0);
        runOp("eq", 32'd77, 32'd77, 1'b0);

        // cancel together with div_valid: nothing accepted
        x = 32'd9; y = 32'd3; div_signed = 1'b0;
        div_valid = 1'b1; cancel = 1'b1;
        @(posedge div_clk); #1;
        div_valid = 1'b0; cancel = 1'b0;
        check("cancel_issue_ready", 32'(div_ready), 32'd1);
        check("cancel_issue_valid", 32'(res_valid), 32'd0);

        // cancel 10 cycles into CALC
        issue(32'd1000, 32'd3, 1'b0);
        repeat (10) @(posedge div_clk);
        #1;
        cancel = 1'b1;
        @(posedge div_clk); #1;
        cancel = 1'b0;
        check("cancel_ready", 32'(div_ready), 32'd1);
        check("cancel_valid", 32'(res_valid), 32'd0);
        runOp("after_cancel", 32'd50, 32'd5, 1'b0);

        // cancelled op must never produce a result
        issue(32'd1000, 32'd3, 1'b0);
        repeat (5) @(posedge div_clk);
        #1;
        cancel = 1'b1;
        @(posedge div_clk); #1;
        cancel = 1'b0;
        sawValid = 1'b0;
        repeat (40) begin
            @(posedge div_clk); #1;
            if (res_valid) sawValid = 1'b1;
        end
        check("cancel_no_result", 32'(sawValid), 32'd0);

        // backpressure in DONE
        res_ready = 1'b0;
        issue(32'd1000, 32'd7, 1'b0);
        waitResult("bp", lat);
        check("bp_s", s, 32'd142);
        check("bp_r", r, 32'd6);
        hs = s;
        hr = r;
        for (int i = 0; i < 5; i++) begin
            @(posedge div_clk); #1;
            check("bp_hold_s", s, hs);
            check("bp_hold_r", r, hr);
            check("bp_hold_flags", {30'd0, div_ready, res_valid}, 32'b01);
        end
        res_ready = 1'b1;
        @(posedge div_clk); #1;
        check("bp_release", {30'd0, div_ready, res_valid}, 32'b10);

        // reset mid-CALC clears everything
        issue(32'd12345, 32'd99, 1'b0);
        repeat (5) @(posedge div_clk);
        #1;
        reset = 1'b1;
        @(posedge div_clk); #1;
        reset = 1'b0;
        check("midrst_ready", 32'(div_ready), 32'd1);
        check("midrst_valid", 32'(res_valid), 32'd0);
        check("midrst_s", s, 32'd0);
        check("midrst_r", r, 32'd0);

        // randomized operands
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            runOp("rand", a, b, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
